wb_ddr_memtest: RTL and testbench
=================================

Name: wb_ddr_memtest

Overview:
- Hardware memory-test engine: a pipelined Wishbone master that drives one LiteDRAM user port in place of the CPU data path.
- Writes a pseudo-random pattern over a word range, then reads the range back and checks it.
- Reports pass/fail, a saturating mismatch count and the first failing address.
- Sits directly upstream of a DDR user port (e.g. user port 1) for DDR bring-up and soak testing without software in the loop.

Parameters:
AW, 26, word-address width (26 = 256MB of 32-bit words)
MaxOutstanding, 8, maximum accepted-but-unacknowledged requests (power of two, 1..16)
ErrCntW, 16, width of mismatch counter

Ports:
clk  in  1  system clock (sys_clk domain)
rst  in  1  asynchronous active-high reset
start  in  1  single-cycle pulse; begins a test when not busy
seed  in  32  LFSR seed, sampled on start; value 0 replaced by 32'h1
base_adr  in  AW  first word address, sampled on start
num_words  in  AW+1  words to test, sampled on start
busy  out  1  test in progress
done  out  1  test finished; held until next accepted start
pass  out  1  valid when done: no mismatch and no bus error
bus_err  out  1  a wb_err was received during the test
err_cnt  out  ErrCntW  read mismatches, saturating
first_err_adr  out  AW  word address of first mismatch
wb_cyc  out  1  Wishbone cycle
wb_stb  out  1  Wishbone strobe
wb_we  out  1  write enable
wb_adr  out  AW  word address
wb_dat_m  out  32  write data
wb_sel  out  4  byte select, always 4'hF
wb_dat_s  in  32  read data
wb_ack  in  1  acknowledge
wb_stall  in  1  pipelined stall
wb_err  in  1  bus error

Behaviour:
- Reset (async, rst=1):
  - All outputs are 0, except wb_sel = 4'hF.
  - State IDLE; counters cleared.
- Pattern:
  - 32-bit Galois LFSR, polynomial x^32+x^22+x^2+x+1 (taps 32'h80200003), shifting right.
  - The word at index i has the value of the LFSR after i steps from seed; index 0 equals seed.
  - Generator LFSR (gen) advances on each accepted strobe (wb_stb & ~wb_stall).
  - Checker LFSR (chk) advances on each read wb_ack.
  - Both LFSRs are reloaded from the seed at the start of each phase.
- Addressing: wb_adr = base_adr + issued_idx, modulo 2^AW (wraps silently).
- States:
  - IDLE: start with num_words=0 → DONE next cycle with pass=1. start with num_words≠0 → latch inputs, clear status, go to WRITE. busy=1 from the cycle after start.
  - WRITE: wb_cyc=1, wb_we=1, wb_dat_m = gen. wb_stb=1 while issued<num_words and outstanding<MaxOutstanding. When issued==num_words, go to WDRAIN.
  - WDRAIN: wb_stb=0. When outstanding==0, deassert wb_cyc for exactly one cycle (GAP), then go to READ.
  - READ: same as WRITE with wb_we=0. On each ack, compare wb_dat_s to chk. On mismatch: err_cnt+1 (saturates at all-ones); on the first mismatch, capture base_adr + ack_idx into first_err_adr.
  - RDRAIN: when outstanding==0 → DONE.
  - DONE: wb_cyc=0, busy=0, done=1, pass = (err_cnt==0) & ~bus_err. A start here restarts as from IDLE.
- Handshake:
  - wb_adr, wb_we and wb_dat_m are held stable while wb_stb & wb_stall.
  - Responses are in order. outstanding increments on an accepted strobe and decrements on ack or err; both in the same cycle leaves it unchanged.
- wb_err:
  - Sets bus_err. No further strobes are issued; the current phase drains to outstanding==0, then goes to DONE (the read phase is skipped if the error occurred during writes).
  - During READ, an err response counts as neither match nor mismatch.
- start while busy is ignored. An ack arriving with outstanding==0 is ignored.
- Reset mid-test: immediate return to IDLE, all outputs 0; the slave sees cyc drop asynchronously.
- Throughput: one accepted request per cycle when there is no stall and outstanding<MaxOutstanding.

Test Plan:
- Seed 32'h1, base 0, 16 words, zero-latency memory model → 16 writes then 16 reads on consecutive cycles, words 0..2 = 32'h1, 32'h80200003, 32'hC0300002; done=1, pass=1, err_cnt=0.
- Model flips bit 0 of the word at addresses 5 and 9, 64 words → err_cnt=2, first_err_adr=5, pass=0.
- Random stall (50%) and 1–20 cycle ack latency, 1000 words → outstanding never exceeds 8, address and data stable under stall, pass=1.
- wb_err on the 4th write → bus_err=1, no further strobes, drain, no read phase, done=1, pass=0.
- base_adr = 2^26−2, 4 words → addresses 3FFFFFE, 3FFFFFF, 0, 1; seed 0 behaves identically to seed 1.
- rst asserted mid-READ with 3 outstanding, then a new start → all outputs 0, the fresh test completes with pass=1. start while busy → no effect. num_words=0 → done one cycle after start with pass=1.

Source files
------------

// File: rtl/wb_ddr_memtest.sv
`timescale 1ns / 1ps
// Wishbone memory-test engine: writes an LFSR pattern over a word range of a
// DRAM user port, reads it back and reports pass/fail, mismatch count and first bad address.
module wb_ddr_memtest #(
   parameter int AW             = 26,
   parameter int MaxOutstanding = 8,
   parameter int ErrCntW        = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [31:0]        seed,
   input  logic [AW-1:0]      base_adr,
   input  logic [AW:0]        num_words,
   output logic               busy,
   output logic               done,
   output logic               pass,
   output logic               bus_err,
   output logic [ErrCntW-1:0] err_cnt,
   output logic [AW-1:0]      first_err_adr,
   output logic               wb_cyc,
   output logic               wb_stb,
   output logic               wb_we,
   output logic [AW-1:0]      wb_adr,
   output logic [31:0]        wb_dat_m,
   output logic [3:0]         wb_sel,
   input  logic [31:0]        wb_dat_s,
   input  logic               wb_ack,
   input  logic               wb_stall,
   input  logic               wb_err
);

   localparam int              OW        = $clog2(MaxOutstanding + 1);
   localparam logic [OW-1:0]   MAX_OUT   = OW'(MaxOutstanding);
   localparam logic [31:0]     LFSR_TAPS = 32'h8020_0003;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WRITE,
      S_WDRAIN,
      S_GAP,
      S_READ,
      S_RDRAIN,
      S_DONE
   } state_t;

   // Galois LFSR x^32+x^22+x^2+x+1, shifting right.
   function automatic logic [31:0] lfsr_step(input logic [31:0] x);
      return (x >> 1) ^ (x[0] ? LFSR_TAPS : 32'h0);
   endfunction

   state_t               r_state;
   state_t               w_state_nxt;
   logic [31:0]          r_seed;
   logic [AW-1:0]        r_base;
   logic [AW:0]          r_num;
   logic [AW:0]          r_issued;
   logic [AW-1:0]        r_ack_idx;
   logic [OW-1:0]        r_outstanding;
   logic [31:0]          r_gen;
   logic [31:0]          r_chk;
   logic                 r_bus_err;
   logic [ErrCntW-1:0]   r_err_cnt;
   logic [AW-1:0]        r_first_err_adr;

   logic                 w_cyc;
   logic                 w_stb;
   logic                 w_we;
   logic                 w_start_ok;
   logic [31:0]          w_seed_fix;
   logic                 w_out_nz;
   logic                 w_rsp;
   logic                 w_rsp_ack;
   logic                 w_rsp_err;
   logic                 w_accept;
   logic                 w_issue_done;
   logic                 w_can_issue;
   logic                 w_read_phase;
   logic                 w_mismatch;

   assign w_start_ok   = start & ((r_state == S_IDLE) | (r_state == S_DONE));
   assign w_seed_fix   = (seed == 32'h0) ? 32'h1 : seed;
   assign w_out_nz     = (r_outstanding != '0);
   // Responses with nothing outstanding are stray and ignored.
   assign w_rsp        = (wb_ack | wb_err) & w_out_nz;
   assign w_rsp_err    = wb_err & w_out_nz;
   assign w_rsp_ack    = wb_ack & ~wb_err & w_out_nz;
   assign w_accept     = w_stb & ~wb_stall;
   assign w_issue_done = (r_issued == r_num);
   assign w_can_issue  = ~w_issue_done & (r_outstanding < MAX_OUT) & ~r_bus_err;
   assign w_read_phase = (r_state == S_READ) | (r_state == S_RDRAIN);
   assign w_mismatch   = w_rsp_ack & w_read_phase & (wb_dat_s != r_chk);

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // pre-edge values regardless of process evaluation order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // NOTE: every signal driven here gets a default first, so no path through the
   // case statement can leave it unassigned and infer a latch.
   always_comb begin
      w_state_nxt = r_state;
      w_cyc       = 1'b0;
      w_stb       = 1'b0;
      w_we        = 1'b0;
      case (r_state)
         S_IDLE, S_DONE: begin
            if (start) begin
               w_state_nxt = (num_words == '0) ? S_DONE : S_WRITE;
            end
         end
         S_WRITE: begin
            w_cyc = 1'b1;
            w_we  = 1'b1;
            w_stb = w_can_issue;
            if (w_issue_done | r_bus_err) begin
               w_state_nxt = S_WDRAIN;
            end
         end
         S_WDRAIN: begin
            w_cyc = 1'b1;
            w_we  = 1'b1;
            if (!w_out_nz) begin
               w_state_nxt = r_bus_err ? S_DONE : S_GAP;
            end
         end
         S_GAP: begin
            w_state_nxt = S_READ;
         end
         S_READ: begin
            w_cyc = 1'b1;
            w_stb = w_can_issue;
            if (w_issue_done | r_bus_err) begin
               w_state_nxt = S_RDRAIN;
            end
         end
         S_RDRAIN: begin
            w_cyc = 1'b1;
            if (!w_out_nz) begin
               w_state_nxt = S_DONE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // Test parameters, latched once per accepted start.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_seed <= '0;
         r_base <= '0;
         r_num  <= '0;
      end else if (w_start_ok) begin
         r_seed <= w_seed_fix;
         r_base <= base_adr;
         r_num  <= num_words;
      end
   end

   // Issue side: generator LFSR and issued index, rewound for each phase.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_gen    <= '0;
         r_issued <= '0;
      end else if (w_start_ok) begin
         r_gen    <= w_seed_fix;
         r_issued <= '0;
      end else if (r_state == S_GAP) begin
         r_gen    <= r_seed;
         r_issued <= '0;
      end else if (w_accept) begin
         r_gen    <= lfsr_step(r_gen);
         r_issued <= r_issued + 1'b1;
      end
   end

   // Check side: advances on every read response (err included) so the expected
   // word stays aligned with the in-order response stream.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_chk     <= '0;
         r_ack_idx <= '0;
      end else if (w_start_ok) begin
         r_chk     <= w_seed_fix;
         r_ack_idx <= '0;
      end else if (r_state == S_GAP) begin
         r_chk     <= r_seed;
         r_ack_idx <= '0;
      end else if (w_rsp && w_read_phase) begin
         r_chk     <= lfsr_step(r_chk);
         r_ack_idx <= r_ack_idx + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_outstanding <= '0;
      end else if (w_start_ok) begin
         r_outstanding <= '0;
      end else if (w_accept && !w_rsp) begin
         r_outstanding <= r_outstanding + 1'b1;
      end else if (!w_accept && w_rsp) begin
         r_outstanding <= r_outstanding - 1'b1;
      end
   end

   // Status: bus error flag, saturating mismatch count, first failing address.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_bus_err       <= 1'b0;
         r_err_cnt       <= '0;
         r_first_err_adr <= '0;
      end else if (w_start_ok) begin
         r_bus_err       <= 1'b0;
         r_err_cnt       <= '0;
         r_first_err_adr <= '0;
      end else begin
         if (w_rsp_err) begin
            r_bus_err <= 1'b1;
         end
         if (w_mismatch) begin
            if (r_err_cnt == '0) begin
               r_first_err_adr <= r_base + r_ack_idx;
            end
            if (r_err_cnt != '1) begin
               r_err_cnt <= r_err_cnt + 1'b1;
            end
         end
      end
   end

   assign busy          = (r_state != S_IDLE) && (r_state != S_DONE);
   assign done          = (r_state == S_DONE);
   assign pass          = done & (r_err_cnt == '0) & ~r_bus_err;
   assign bus_err       = r_bus_err;
   assign err_cnt       = r_err_cnt;
   assign first_err_adr = r_first_err_adr;
   assign wb_cyc        = w_cyc;
   assign wb_stb        = w_stb;
   assign wb_we         = w_we;
   assign wb_adr        = r_base + r_issued[AW-1:0];
   assign wb_dat_m      = w_we ? r_gen : 32'h0;
   assign wb_sel        = 4'hF;

endmodule

// File: tb/tb_wb_ddr_memtest.sv
`timescale 1ns / 1ps
// Scoreboard bench for wb_ddr_memtest: a pipelined Wishbone memory model with
// configurable stall/latency/fault injection, plus a done-result monitor.
module tb_wb_ddr_memtest;

   localparam int AW = 26;
   localparam int MO = 8;
   localparam int EW = 16;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic [31:0]   seed = '0;
   logic [AW-1:0] base_adr = '0;
   logic [AW:0]   num_words = '0;
   logic          busy, done, pass, bus_err;
   logic [EW-1:0] err_cnt;
   logic [AW-1:0] first_err_adr;
   logic          wb_cyc, wb_stb, wb_we;
   logic [AW-1:0] wb_adr;
   logic [31:0]   wb_dat_m;
   logic [3:0]    wb_sel;
   logic [31:0]   wb_dat_s = '0;
   logic          wb_ack = 1'b0;
   logic          wb_stall = 1'b0;
   logic          wb_err = 1'b0;

   wb_ddr_memtest #(.AW(AW), .MaxOutstanding(MO), .ErrCntW(EW)) dut (
      .clk(clk), .rst(rst), .start(start), .seed(seed), .base_adr(base_adr),
      .num_words(num_words), .busy(busy), .done(done), .pass(pass),
      .bus_err(bus_err), .err_cnt(err_cnt), .first_err_adr(first_err_adr),
      .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we), .wb_adr(wb_adr),
      .wb_dat_m(wb_dat_m), .wb_sel(wb_sel), .wb_dat_s(wb_dat_s),
      .wb_ack(wb_ack), .wb_stall(wb_stall), .wb_err(wb_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic          pass;
      logic          bus_err;
      logic [EW-1:0] err_cnt;
      logic [AW-1:0] first;
   } result_t;

   typedef struct {
      logic          we;
      logic [AW-1:0] adr;
      logic [31:0]   dat;
   } stb_t;

   typedef struct {
      logic        err;
      logic [31:0] dat;
      int          due;
   } rsp_t;

   result_t     exp_res[$];
   stb_t        exp_stb[$];
   rsp_t        rsp_q[$];
   logic [31:0] mem [logic [AW-1:0]];

   int checks = 0;
   int errors = 0;

   // Slave configuration
   logic stall_en = 1'b0;
   logic flip_en  = 1'b0;
   int   lat_min = 1, lat_max = 1, err_at_wr = 0;

   // Per-test observations
   int   cyc_n = 0, n_wr = 0, n_rd = 0, tb_outst = 0, max_outst = 0;
   int   stab_viol = 0, stb_after_err = 0;
   int   first_wr = 0, last_wr = 0, first_rd = 0, last_rd = 0;
   logic err_sent = 1'b0;
   logic prev_hold = 1'b0, prev_we = 1'b0, prev_done = 1'b0;
   logic [AW-1:0] prev_adr = '0;
   logic [31:0]   prev_dat = '0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic result_t mk_res(input logic p, input logic be, input logic [EW-1:0] ec,
                                      input logic [AW-1:0] fa);
      result_t r;
      r.pass = p; r.bus_err = be; r.err_cnt = ec; r.first = fa;
      return r;
   endfunction

   function automatic stb_t mk_stb(input logic we, input logic [AW-1:0] adr, input logic [31:0] dat);
      stb_t s;
      s.we = we; s.adr = adr; s.dat = dat;
      return s;
   endfunction

   // Memory slave: acts on the falling edge so its inputs are stable at the next rising edge.
   initial begin
      forever begin
         rsp_t r;
         stb_t e;
         @(negedge clk);
         cyc_n++;
         if (rst) begin
            rsp_q.delete();
            tb_outst = 0;
            wb_ack = 1'b0; wb_err = 1'b0; wb_dat_s = '0; wb_stall = 1'b0;
            prev_hold = 1'b0;
         end else begin
            if (prev_hold && (!wb_stb || wb_we != prev_we || wb_adr != prev_adr || wb_dat_m != prev_dat))
               stab_viol++;
            if (err_sent && wb_stb) stb_after_err++;
            wb_ack = 1'b0; wb_err = 1'b0; wb_dat_s = '0;
            if (rsp_q.size() > 0 && rsp_q[0].due <= cyc_n) begin
               r = rsp_q.pop_front();
               if (r.err) begin
                  wb_err = 1'b1;
                  err_sent = 1'b1;
               end else begin
                  wb_ack = 1'b1;
                  wb_dat_s = r.dat;
               end
               tb_outst--;
            end
            wb_stall = stall_en ? 1'($urandom_range(0, 1)) : 1'b0;
            if (wb_stb && !wb_stall) begin
               r.err = 1'b0;
               r.dat = '0;
               if (wb_we) begin
                  n_wr++;
                  if (n_wr == 1) first_wr = cyc_n;
                  last_wr = cyc_n;
                  r.err = (n_wr == err_at_wr);
                  if (!r.err) mem[wb_adr] = wb_dat_m;
               end else begin
                  n_rd++;
                  if (n_rd == 1) first_rd = cyc_n;
                  last_rd = cyc_n;
                  r.dat = mem.exists(wb_adr) ? mem[wb_adr] : 32'hDEAD_BEEF;
                  if (flip_en && (wb_adr == 26'd5 || wb_adr == 26'd9)) r.dat[0] = ~r.dat[0];
               end
               if (exp_stb.size() > 0) begin
                  e = exp_stb.pop_front();
                  check("stb_we", 64'(wb_we), 64'(e.we));
                  check("stb_adr", 64'(wb_adr), 64'(e.adr));
                  if (e.we) check("stb_dat", 64'(wb_dat_m), 64'(e.dat));
               end
               r.due = cyc_n + int'($urandom_range(lat_min, lat_max));
               rsp_q.push_back(r);
               tb_outst++;
            end
            if (tb_outst > max_outst) max_outst = tb_outst;
            prev_hold = wb_stb && wb_stall;
            prev_we = wb_we; prev_adr = wb_adr; prev_dat = wb_dat_m;
         end
      end
   end

   // Result monitor: fires when done rises or a zero-length start re-enters DONE.
   initial begin
      forever begin
         result_t e;
         @(posedge clk);
         #1;
         if (done && (!prev_done || start)) begin
            if (exp_res.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_done: got done=1 expected no result pending");
            end else begin
               e = exp_res.pop_front();
               check("res_pass", 64'(pass), 64'(e.pass));
               check("res_bus_err", 64'(bus_err), 64'(e.bus_err));
               check("res_err_cnt", 64'(err_cnt), 64'(e.err_cnt));
               check("res_first_err_adr", 64'(first_err_adr), 64'(e.first));
               check("res_busy", 64'(busy), 64'd0);
            end
         end
         prev_done = done;
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic start_test(input logic [31:0] s, input logic [AW-1:0] b, input logic [AW:0] n);
      n_wr = 0; n_rd = 0; max_outst = 0; stab_viol = 0; stb_after_err = 0; err_sent = 1'b0;
      seed = s; base_adr = b; num_words = n;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_done(input int budget, input string name);
      int k = 0;
      while (exp_res.size() != 0 && k < budget) begin
         tick();
         k++;
      end
      if (exp_res.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL %s_timeout: got no done after %0d cycles expected done", name, budget);
         exp_res.delete();
      end
   endtask

   task automatic check_idle_outputs(input string name);
      check({name, "_flags"}, 64'({busy, done, pass, bus_err, wb_cyc, wb_stb, wb_we}), 64'd0);
      check({name, "_err_cnt"}, 64'(err_cnt), 64'd0);
      check({name, "_first_err_adr"}, 64'(first_err_adr), 64'd0);
      check({name, "_adr_dat"}, {6'd0, wb_adr, wb_dat_m}, 64'd0);
      check({name, "_sel"}, 64'(wb_sel), 64'hF);
   endtask

   initial begin
      int k;
      rst = 1'b1;
      repeat (3) tick();
      check_idle_outputs("reset");
      rst = 1'b0;
      tick();

      // T1: seed 1, 16 words, back-to-back
      exp_stb.push_back(mk_stb(1'b1, 26'd0, 32'h0000_0001));
      exp_stb.push_back(mk_stb(1'b1, 26'd1, 32'h8020_0003));
      exp_stb.push_back(mk_stb(1'b1, 26'd2, 32'hC030_0002));
      exp_res.push_back(mk_res(1'b1, 1'b0, '0, '0));
      start_test(32'h1, 26'd0, 27'd16);
      wait_done(500, "t1");
      check("t1_n_wr", 64'(n_wr), 64'd16);
      check("t1_n_rd", 64'(n_rd), 64'd16);
      check("t1_wr_span", 64'(last_wr - first_wr), 64'd15);
      check("t1_rd_span", 64'(last_rd - first_rd), 64'd15);

      // T2: bit 0 flipped at addresses 5 and 9
      flip_en = 1'b1;
      exp_res.push_back(mk_res(1'b0, 1'b0, 16'd2, 26'd5));
      start_test(32'h1234_5678, 26'd0, 27'd64);
      wait_done(1000, "t2");
      flip_en = 1'b0;

      // T3: random stall and latency, 1000 words, with an ignored start mid-test
      stall_en = 1'b1; lat_min = 1; lat_max = 20;
      exp_res.push_back(mk_res(1'b1, 1'b0, '0, '0));
      start_test(32'hCAFE_F00D, 26'h100, 27'd1000);
      repeat (50) tick();
      seed = 32'h55; num_words = 27'd5;
      start = 1'b1;
      tick();
      start = 1'b0;
      check("busy_start_ignored", 64'({busy, done}), 64'b10);
      wait_done(20000, "t3");
      check("t3_max_outst_le8", 64'(max_outst <= MO), 64'd1);
      check("t3_stable_under_stall", 64'(stab_viol), 64'd0);
      check("t3_n_wr", 64'(n_wr), 64'd1000);
      check("t3_n_rd", 64'(n_rd), 64'd1000);
      stall_en = 1'b0; lat_min = 1; lat_max = 1;

      // T4: error response on the 4th write
      err_at_wr = 4;
      exp_res.push_back(mk_res(1'b0, 1'b1, '0, '0));
      start_test(32'h1, 26'd0, 27'd16);
      wait_done(500, "t4");
      check("t4_no_stb_after_err", 64'(stb_after_err), 64'd0);
      check("t4_n_wr", 64'(n_wr), 64'd5);
      check("t4_no_reads", 64'(n_rd), 64'd0);
      err_at_wr = 0;

      // T5: address wrap, seed 0 treated as seed 1
      exp_stb.push_back(mk_stb(1'b1, 26'h3FF_FFFE, 32'h0000_0001));
      exp_stb.push_back(mk_stb(1'b1, 26'h3FF_FFFF, 32'h8020_0003));
      exp_stb.push_back(mk_stb(1'b1, 26'h000_0000, 32'hC030_0002));
      exp_stb.push_back(mk_stb(1'b1, 26'h000_0001, 32'h6018_0001));
      exp_stb.push_back(mk_stb(1'b0, 26'h3FF_FFFE, 32'h0));
      exp_stb.push_back(mk_stb(1'b0, 26'h3FF_FFFF, 32'h0));
      exp_stb.push_back(mk_stb(1'b0, 26'h000_0000, 32'h0));
      exp_stb.push_back(mk_stb(1'b0, 26'h000_0001, 32'h0));
      exp_res.push_back(mk_res(1'b1, 1'b0, '0, '0));
      start_test(32'h0, 26'h3FF_FFFE, 27'd4);
      wait_done(500, "t5");
      check("t5_stb_queue_drained", 64'(exp_stb.size()), 64'd0);

      // T6: reset during the read phase with 3 outstanding, then a fresh test
      lat_min = 5; lat_max = 5;
      start_test(32'h7, 26'h200, 27'd32);
      k = 0;
      while (!(wb_cyc && !wb_we && tb_outst == 3) && k < 1000) begin
         tick();
         k++;
      end
      check("t6_reached_read_out3", 64'(k < 1000), 64'd1);
      rst = 1'b1;
      #1;
      check_idle_outputs("midreset");
      repeat (2) tick();
      rst = 1'b0;
      tick();
      exp_res.push_back(mk_res(1'b1, 1'b0, '0, '0));
      start_test(32'h0BAD_F00D, 26'h40, 27'd20);
      wait_done(1000, "t6");
      lat_min = 1; lat_max = 1;

      // T7: zero-length test completes one cycle after start
      exp_res.push_back(mk_res(1'b1, 1'b0, '0, '0));
      start_test(32'h9, 26'd0, 27'd0);
      check("t7_done_next_cycle", 64'({done, pass}), 64'b11);
      wait_done(10, "t7");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
